// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Holds the R-type opcode, the HI/LO-related funct codes, the sequencer
// state enum and the latched operation kind.
package muldiv_pkg;

  localparam logic [5:0] OpRtype    = 6'h00;

  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMtlo  = 6'h13;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StRun, StFixup} md_state_e;

  typedef enum logic [1:0] {OpMulS, OpMulU, OpDivS, OpDivU} md_op_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : 2*Width accumulator {upper, lower}
//              multiply: {partial product, remaining multiplier bits}
//              divide:   {partial remainder, dividend bits / quotient bits}
//   opb_i    : multiplicand or divisor magnitude
//   acc_o    : accumulator after this iteration
module muldiv_step #(
  parameter int unsigned Width = 32
) (
  input  logic                 is_div_i,
  input  logic [2*Width-1:0]   acc_i,
  input  logic [Width-1:0]     opb_i,
  output logic [2*Width-1:0]   acc_o
);

  logic [Width:0] sum;
  logic [Width:0] rem_sh;
  logic [Width:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*Width-1:Width]} + {1'b0, opb_i};
    // Remainder shifted left with the next dividend bit brought in.
    rem_sh = acc_i[2*Width-1:Width-1];
    diff   = rem_sh - {1'b0, opb_i};
    acc_o  = acc_i;
    if (is_div_i) begin
      // rem_sh < 2*divisor, so a non-negative difference always fits in Width bits.
      if (!diff[Width]) begin
        acc_o = {diff[Width-1:0], acc_i[Width-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[Width-1:0], acc_i[Width-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {sum, acc_i[Width-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*Width-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
//   clk, rst            : clock, synchronous active-high reset
//   valid_e/op_e/funct_e: instruction currently in EX
//   srca_e, srcb_e      : forwarded rs/rt operands
//   flush_e             : EX instruction squashed this cycle
//   stall_md            : hold IF/ID/EX (HI/LO instruction while a sequence runs)
//   busy                : a sequence is in flight
//   mf_data             : HI or LO for MFHI/MFLO
//   hi, lo              : architectural HI/LO
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_e,
  input  logic [5:0]       op_e,
  input  logic [5:0]       funct_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             flush_e,
  output logic             stall_md,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               md_ins, start_fn, signed_fn, a_neg, b_neg, op_is_div;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] prod;

  assign op_is_div = (op_q == OpDivS) || (op_q == OpDivU);

  muldiv_step #(
    .Width (WIDTH)
  ) u_step (
    .is_div_i (op_is_div),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    md_ins    = valid_e & ~flush_e & (op_e == OpRtype) &
                (funct_e inside {FunctMfhi, FunctMthi, FunctMflo, FunctMtlo,
                                 FunctMult, FunctMultu, FunctDiv, FunctDivu});
    start_fn  = funct_e inside {FunctMult, FunctMultu, FunctDiv, FunctDivu};
    signed_fn = (funct_e == FunctMult) || (funct_e == FunctDiv);
    a_neg     = signed_fn & srca_e[WIDTH-1];
    b_neg     = signed_fn & srcb_e[WIDTH-1];
    a_mag     = a_neg ? (~srca_e + 1'b1) : srca_e;
    b_mag     = b_neg ? (~srcb_e + 1'b1) : srcb_e;

    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];

    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (md_ins) begin
          if (start_fn) begin
            state_d   = StRun;
            cnt_d     = CntW'(WIDTH);
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            opb_d     = b_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            unique case (funct_e)
              FunctMult:  op_d = OpMulS;
              FunctMultu: op_d = OpMulU;
              FunctDiv:   op_d = OpDivS;
              default:    op_d = OpDivU;
            endcase
          end else if (funct_e == FunctMthi) begin
            hi_d = srca_e;
          end else if (funct_e == FunctMtlo) begin
            lo_d = srca_e;
          end
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        state_d = StIdle;
        if (op_is_div) begin
          // Divide by zero: quotient forced to all ones; the remainder path
          // already reproduces the dividend once its sign is restored.
          lo_d = (opb_q == '0) ? '1 : (neg_q ? (~quot + 1'b1) : quot);
          hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMulS;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign stall_md = md_ins & (state_q != StIdle);
  assign mf_data  = (funct_e == FunctMfhi) ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam logic [5:0] FMfhi = 6'h10, FMthi = 6'h11, FMflo = 6'h12, FMtlo = 6'h13;
  localparam logic [5:0] FMult = 6'h18, FMultu = 6'h19, FDiv = 6'h1A, FDivu = 6'h1B;
  localparam logic [5:0] FAdd  = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e;
  logic [5:0]  op_e;
  logic [5:0]  funct_e;
  logic [31:0] srca_e, srcb_e;
  logic        flush_e;
  logic        stall_md, busy;
  logic [31:0] mf_data, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_e  (valid_e),
    .op_e     (op_e),
    .funct_e  (funct_e),
    .srca_e   (srca_e),
    .srcb_e   (srcb_e),
    .flush_e  (flush_e),
    .stall_md (stall_md),
    .busy     (busy),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    h = '0;
    l = '0;
    case (f)
      FMult: begin
        sp = sa * sb;
        h = sp[63:32];
        l = sp[31:0];
      end
      FMultu: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      FDiv: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          h = sr[31:0];
          l = sq[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    valid_e = v;
    op_e    = 6'h00;
    funct_e = f;
    srca_e  = a;
    srcb_e  = b;
    flush_e = fl;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    @(negedge clk);
    drive(1'b1, f, a, b, 1'b0);
    #1;
    chk({tag, "_start_nostall"}, {31'b0, stall_md}, 32'd0);
    @(negedge clk);
    valid_e = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd33);
    model(f, a, b, exp_hi, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    logic [5:0] fsel [4];
    fsel[0] = FMult; fsel[1] = FMultu; fsel[2] = FDiv; fsel[3] = FDivu;

    rst = 1'b1;
    drive(1'b0, 6'h00, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_stall", {31'b0, stall_md}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op(FMult,  32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
    chk("mult_neg1x2_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg1x2_lo_const", lo, 32'hFFFF_FFFE);
    run_op(FMultu, 32'hFFFF_FFFF, 32'h2, "multu");
    chk("multu_hi_const", hi, 32'h1);
    run_op(FDiv,   32'hFFFF_FFF9, 32'h2, "div_m7_2");
    chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
    run_op(FDivu,  32'd100, 32'd7, "divu_100_7");
    run_op(FDivu,  32'd5, 32'd0, "divu_by0");
    run_op(FDiv,   32'hFFFF_FFFB, 32'd0, "div_neg_by0");
    run_op(FDiv,   32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
    chk("div_wrap_lo_const", lo, 32'h8000_0000);

    // MFLO right behind a MULT stalls for the whole sequence.
    @(negedge clk);
    drive(1'b1, FMult, 32'd12345, 32'hFFFF_FFF0, 1'b0);
    @(negedge clk);
    drive(1'b1, FMflo, '0, '0, 1'b0);
    n = 0;
    while (stall_md === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    model(FMult, 32'd12345, 32'hFFFF_FFF0, exp_hi, exp_lo);
    chk("mflo_stall_cycles", n, 32'd33);
    chk("mflo_data", mf_data, exp_lo);
    funct_e = FMfhi;
    #1;
    chk("mfhi_data", mf_data, exp_hi);
    @(negedge clk);
    valid_e = 1'b0;

    // Unrelated ADD does not stall.
    @(negedge clk);
    drive(1'b1, FMultu, 32'd7, 32'd6, 1'b0);
    @(negedge clk);
    drive(1'b1, FAdd, '0, '0, 1'b0);
    #1;
    chk("add_nostall", {31'b0, stall_md}, 32'd0);
    chk("add_busy", {31'b0, busy}, 32'd1);
    valid_e = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp_hi = 32'd0;
    exp_lo = 32'd42;
    chk("add_case_lo", lo, exp_lo);

    // MTHI while idle.
    @(negedge clk);
    drive(1'b1, FMthi, 32'h1234, '0, 1'b0);
    @(negedge clk);
    valid_e = 1'b0;
    exp_hi = 32'h1234;
    chk("mthi_idle", hi, exp_hi);
    @(negedge clk);
    drive(1'b1, FMtlo, 32'h5678, '0, 1'b0);
    @(negedge clk);
    valid_e = 1'b0;
    exp_lo = 32'h5678;
    chk("mtlo_idle", lo, exp_lo);

    // MTHI during RUN waits, then overrides the multiply's HI.
    @(negedge clk);
    drive(1'b1, FMult, 32'hFFFF_FFFD, 32'd5, 1'b0);
    @(negedge clk);
    drive(1'b1, FMthi, 32'hABCD, '0, 1'b0);
    n = 0;
    while (stall_md === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mthi_run_stall", n, 32'd33);
    chk("mthi_run_hi_before", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    valid_e = 1'b0;
    exp_hi = 32'hABCD;
    exp_lo = 32'hFFFF_FFF1;
    chk("mthi_run_hi", hi, exp_hi);
    chk("mthi_run_lo", lo, exp_lo);

    // Flushed MULT never starts.
    @(negedge clk);
    drive(1'b1, FMult, 32'd7, 32'd9, 1'b1);
    #1;
    chk("flush_nostall", {31'b0, stall_md}, 32'd0);
    @(negedge clk);
    drive(1'b0, 6'h00, '0, '0, 1'b0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_hi", hi, exp_hi);
    chk("flush_lo", lo, exp_lo);

    // Reset in the middle of a DIV abandons it.
    @(negedge clk);
    drive(1'b1, FDiv, 32'hFFFF_FF9C, 32'd7, 1'b0);
    @(negedge clk);
    valid_e = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_write_lo", lo, 32'd0);
    run_op(FDiv, 32'hFFFF_FF9C, 32'd7, "div_after_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      run_op(fsel[$urandom_range(0, 3)], pick(), pick(), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the pipelined MIPS core. It sits beside the EX-stage ALU and owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from EX and runs them as a 32-step shift-add or restoring-divide sequence. It stalls the pipeline whenever a later HI/LO-dependent instruction reaches EX before the result is ready.

## Interface
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `valid_e`  in  1: a valid instruction is in EX.
- `op_e`  in  6: opcode in EX; only `6'h00` (R-type) is decoded.
- `funct_e`  in  6: funct field in EX.
- `srca_e`, `srcb_e`  in  WIDTH: forwarded rs and rt operands.
- `flush_e`  in  1: the EX instruction is being squashed this cycle.
- `stall_md`  out  1: hold IF/ID/EX this cycle.
- `busy`  out  1: a sequence is in flight.
- `mf_data`  out  WIDTH: HI or LO value for MFHI/MFLO in EX.
- `hi`, `lo`  out  WIDTH: architectural HI/LO registers.

## Operation
- Decoded functs (R-type only): MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- `md_ins` = `valid_e & ~flush_e & op_e==0 &` any of those eight functs.
- FSM states:
  - IDLE → RUN when a MULT/MULTU/DIV/DIVU is accepted.
  - RUN loads `WIDTH` steps into a counter and decrements it each cycle; moves to FIXUP when the counter reaches 1.
  - FIXUP → IDLE.
- Start (IDLE only):
  - Latch operand magnitudes; signed ops take absolute values.
  - Latch a negate-product or negate-quotient flag (operand signs differ), a negate-remainder flag (dividend negative), and the op kind.
  - The starting instruction does not stall.
- RUN, multiply: 2·WIDTH-bit accumulator, one conditional add and right shift per cycle.
- RUN, divide: restoring division, one remainder shift/subtract/restore and one quotient bit per cycle.
- FIXUP: apply sign corrections, then write HI/LO.
  - Multiply: HI = upper half, LO = lower half of the two's-complement product.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = all ones, HI = dividend unchanged. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural wrap.
- MTHI/MTLO in IDLE: write `srca_e` to HI/LO at the cycle's end.
- MFHI/MFLO: `mf_data` is a combinational mux of the current `hi`/`lo`.
- `stall_md = md_ins & (state != IDLE)`. Any HI/LO-touching instruction in EX during RUN or FIXUP, including a second multiply/divide, waits. It proceeds in the first IDLE cycle.
- `busy = (state != IDLE)`.
- Flush: `flush_e` in the start cycle prevents the start. Flush never aborts an in-flight sequence, because that instruction has already retired from EX.
- Reset values: state IDLE, `hi`/`lo` = 0, `busy` = 0, `stall_md` = 0, counter = 0. `rst` mid-sequence abandons the operation with no HI/LO write.

## Timing
- Start accepted in cycle T.
- RUN occupies T+1 … T+WIDTH.
- FIXUP occurs in T+WIDTH+1; HI/LO update at the end of that cycle.
- IDLE resumes in T+WIDTH+2. Total latency: 34 cycles at WIDTH=32.
- MFLO entering EX at T+1 stalls for exactly 33 cycles. It reads the new LO in cycle T+34.
- Back-to-back MULT in T and T+1: the second stalls 33 cycles and starts at T+34.
- MTLO and MFLO never see a partial result. HI/LO change only in FIXUP or via MT in IDLE.
- All outputs except `stall_md` and `mf_data` are registered.

## Structure
- `muldiv_pkg` holds:
  - the eight funct localparams and the R-type opcode constant;
  - the state enum {IDLE, RUN, FIXUP};
  - the op-kind enum {MUL_S, MUL_U, DIV_S, DIV_U}.
- The arithmetic is split into a natural sub-module, `muldiv_step`. It is combinational and performs one shift-add or restoring-divide iteration on the accumulator/remainder. The sequencer keeps the FSM, counter, sign flags, and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 34 cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2. DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- MULT in T, MFLO in T+1 → `stall_md` high for exactly 33 cycles. `mf_data` equals the new LO in T+34. An unrelated ADD in T+1 is not stalled.
- MTHI 0x1234 while idle → `hi` = 0x1234 next cycle. MTHI during RUN → stalls, then writes after FIXUP and overrides the MULT's HI.
- MULT with `flush_e` = 1 in T → no start, `busy` stays 0, HI/LO unchanged.
- `rst` asserted at T+10 of a DIV → next cycle IDLE, `hi` = `lo` = 0, `busy` = 0. A subsequent DIV completes correctly.
